// File: rtl/imem_pkg.sv
// Shared types, constants and the address check for the instruction fetch arbiter.
package imem_pkg;

    // Instruction returned in place of memory data for a rejected address (addi x0,x0,0).
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    // Default instruction memory geometry.
    localparam int unsigned ADDRESS_WIDTH_DEFAULT = 8;
    localparam int unsigned MEM_BYTES = 2 ** ADDRESS_WIDTH_DEFAULT;

    typedef enum logic {
        ARB_NORMAL  = 1'b0,
        ARB_FORCE_D = 1'b1
    } arb_state_t;

    // Flags a word fetch that is misaligned or whose last byte lies outside a
    // 2**addr_width byte memory. The full address is compared, so any set bit
    // above the memory range is rejected rather than wrapped.
    function automatic logic addr_bad(input logic [63:0] addr, input int unsigned addr_width);
        logic [63:0] last_word;
        last_word = (64'd1 << addr_width) - 64'd4;
        return (addr[1:0] != 2'b00) || (addr > last_word);
    endfunction

endpackage

// File: rtl/imem_rsp_slot.sv
// One-entry valid/ready response register: load on grant, drain on ready, clear on flush.
module imem_rsp_slot #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  load_i,
    input  logic                  clear_i,
    input  logic [DATA_WIDTH-1:0] instr_i,
    input  logic                  err_i,
    input  logic                  rsp_ready_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_instr_o,
    output logic                  rsp_err_o,
    output logic                  free_o
);

    logic                  valid_reg;
    logic [DATA_WIDTH-1:0] instr_reg;
    logic                  err_reg;

    // Slot can accept a new grant when empty or being consumed this cycle.
    always_comb begin
        free_o = !valid_reg || rsp_ready_i;
    end

    // Clear beats everything; a load on a draining edge keeps the slot full.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_reg <= 1'b0;
            instr_reg <= '0;
            err_reg   <= 1'b0;
        end else if (clear_i) begin
            valid_reg <= 1'b0;
            instr_reg <= '0;
            err_reg   <= 1'b0;
        end else if (load_i) begin
            valid_reg <= 1'b1;
            instr_reg <= instr_i;
            err_reg   <= err_i;
        end else if (valid_reg && rsp_ready_i) begin
            valid_reg <= 1'b0;
        end
    end

    assign rsp_valid_o = valid_reg;
    assign rsp_instr_o = instr_reg;
    assign rsp_err_o   = err_reg;

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Two-requester arbiter for the instruction memory read port: fetch has priority,
// debug is guaranteed a grant after MAX_WAIT consecutive losses.
module imem_fetch_arbiter
    import imem_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_WAIT      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  f_req_valid_i,
    output logic                  f_req_ready_o,
    input  logic [DATA_WIDTH-1:0] f_addr_i,
    input  logic                  f_flush_i,
    output logic                  f_rsp_valid_o,
    input  logic                  f_rsp_ready_i,
    output logic [DATA_WIDTH-1:0] f_rsp_instr_o,
    output logic                  f_rsp_err_o,
    input  logic                  d_req_valid_i,
    output logic                  d_req_ready_o,
    input  logic [DATA_WIDTH-1:0] d_addr_i,
    output logic                  d_rsp_valid_o,
    input  logic                  d_rsp_ready_i,
    output logic [DATA_WIDTH-1:0] d_rsp_instr_o,
    output logic                  d_rsp_err_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_instr_i
);

    arb_state_t  state_reg, state_next;
    logic [3:0]  wait_cnt_reg, wait_cnt_next;
    logic        f_free, d_free;
    logic        f_elig, d_elig;
    logic        f_grant, d_grant;
    logic        addr_err;
    logic [DATA_WIDTH-1:0] load_instr;

    // Arbitration state and the debug starvation counter.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg    <= ARB_NORMAL;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // Grant selection, counter update and next-state decision.
    always_comb begin
        f_elig        = f_req_valid_i && f_free && !f_flush_i;
        d_elig        = d_req_valid_i && d_free;
        f_grant       = 1'b0;
        d_grant       = 1'b0;
        wait_cnt_next = wait_cnt_reg;
        state_next    = state_reg;

        if (state_reg == ARB_FORCE_D) begin
            d_grant = d_elig;
            f_grant = !d_elig && f_elig;
        end else begin
            f_grant = f_elig;
            d_grant = !f_elig && d_elig;
        end

        // A D loss only counts while D could actually have been served.
        if (d_grant || !d_req_valid_i) begin
            wait_cnt_next = '0;
        end else if (d_elig && wait_cnt_reg != 4'hF) begin
            wait_cnt_next = wait_cnt_reg + 4'd1;
        end

        if (state_reg == ARB_FORCE_D) begin
            if (d_grant || !d_req_valid_i) begin
                state_next = ARB_NORMAL;
            end
        end else if (wait_cnt_next >= 4'(MAX_WAIT)) begin
            state_next = ARB_FORCE_D;
        end
    end

    // Memory port follows the winner; idle cycles present the fetch address.
    always_comb begin
        mem_addr_o = d_grant ? d_addr_i : f_addr_i;
        addr_err   = addr_bad(64'(mem_addr_o), ADDRESS_WIDTH);
        load_instr = addr_err ? DATA_WIDTH'(NOP_INSTR) : mem_instr_i;
    end

    assign f_req_ready_o = f_grant;
    assign d_req_ready_o = d_grant;

    imem_rsp_slot #(.DATA_WIDTH(DATA_WIDTH)) u_f_slot (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .load_i      (f_grant),
        .clear_i     (f_flush_i),
        .instr_i     (load_instr),
        .err_i       (addr_err),
        .rsp_ready_i (f_rsp_ready_i),
        .rsp_valid_o (f_rsp_valid_o),
        .rsp_instr_o (f_rsp_instr_o),
        .rsp_err_o   (f_rsp_err_o),
        .free_o      (f_free)
    );

    imem_rsp_slot #(.DATA_WIDTH(DATA_WIDTH)) u_d_slot (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .load_i      (d_grant),
        .clear_i     (1'b0),
        .instr_i     (load_instr),
        .err_i       (addr_err),
        .rsp_ready_i (d_rsp_ready_i),
        .rsp_valid_o (d_rsp_valid_o),
        .rsp_instr_o (d_rsp_instr_o),
        .rsp_err_o   (d_rsp_err_o),
        .free_o      (d_free)
    );

endmodule

// File: doc/imem_fetch_arbiter.md
Name: imem_fetch_arbiter

Overview:
- Shares the single combinational, byte-addressed instruction memory read port between two requesters.
- Requester F is the pipeline fetch stage (high priority). Requester D is the debug/loader read-back port (low priority, starvation-bounded).
- Each accepted request returns a registered 32-bit instruction one cycle later through a per-requester valid/ready response slot.
- Sits between the fetch stage / debug module and the instruction memory; adds alignment and range checking.

Parameters:
- ADDRESS_WIDTH, 8, memory byte-address width; memory holds 2**ADDRESS_WIDTH bytes.
- DATA_WIDTH, 32, address and instruction width.
- MAX_WAIT, 4, maximum consecutive cycles an eligible D request may lose before it is forced to win (legal range 1..15).

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- f_req_valid_i  in  1  fetch request valid.
- f_req_ready_o  out  1  fetch request accepted this cycle.
- f_addr_i  in  DATA_WIDTH  fetch byte address.
- f_flush_i  in  1  kill fetch response slot, block fetch grant this cycle.
- f_rsp_valid_o  out  1  fetch response valid.
- f_rsp_ready_i  in  1  fetch response consumed.
- f_rsp_instr_o  out  DATA_WIDTH  fetched instruction.
- f_rsp_err_o  out  1  misaligned or out-of-range fetch.
- d_req_valid_i, d_req_ready_o, d_addr_i, d_rsp_valid_o, d_rsp_ready_i, d_rsp_instr_o, d_rsp_err_o: same as the F ports, for the debug requester. There is no flush on D.
- mem_addr_o  out  DATA_WIDTH  address to instruction memory.
- mem_instr_i  in  DATA_WIDTH  combinational little-endian instruction from memory.

Behaviour:
- Reset (async, rst_n_i=0):
  - All rsp_valid=0, rsp_instr=0, rsp_err=0.
  - Starvation counter=0; state=ARB_NORMAL.
  - Reset mid-operation discards held responses.
- Eligibility:
  - X is eligible when X_req_valid=1 and its slot is empty, or its slot is draining this cycle (rsp_valid & rsp_ready).
  - F is additionally ineligible while f_flush_i=1.
- Grant rule: at most one grant per cycle; X_req_ready_o=1 exactly for the granted requester (combinational).
  - ARB_NORMAL: F wins if eligible; otherwise D wins if eligible.
  - ARB_FORCE_D: D wins if eligible; otherwise F wins.
- Counter and state:
  - Counter +1 each cycle D is eligible but not granted.
  - Counter clears to 0 on a D grant or when D is not valid.
  - When the counter reaches MAX_WAIT, next state is ARB_FORCE_D.
  - ARB_FORCE_D returns to ARB_NORMAL after a D grant or when D drops valid.
- Memory address: mem_addr_o = granted address; with no grant, mem_addr_o = f_addr_i.
- Capture: at the edge after a grant, the slot loads instr=mem_instr_i, err=chk, rsp_valid=1. Latency is exactly 1 cycle from grant to rsp_valid.
  - chk=1 if addr[1:0]!=0 or addr > 2**ADDRESS_WIDTH-4.
  - When chk=1, instr is forced to NOP 32'h00000013.
- Hold: rsp_valid, instr and err stay stable until rsp_ready=1.
  - A same-edge drain and new grant reloads the slot; rsp_valid stays 1.
- Flush: f_flush_i=1 clears the F slot (f_rsp_valid_o=0) at the next edge, overriding any hold. No F grant occurs that cycle.
- D traffic is never affected by f_flush_i.
- Address arithmetic: compare uses the full DATA_WIDTH address. Upper bits above ADDRESS_WIDTH set are out of range; there is no wrap-around.

Decomposition:
- Package imem_pkg:
  - NOP_INSTR constant 32'h00000013.
  - Enum arb_state_t {ARB_NORMAL, ARB_FORCE_D}.
  - Localparam MEM_BYTES = 2**ADDRESS_WIDTH; the range-check function.
- Sub-module imem_rsp_slot (one-entry valid/ready response register with load/drain/clear), instantiated twice. Arbitration and counter logic live in the top module.

Test Plan:
- Reset hold, then release with F valid at addr 0x00 and memory returning 0x00500093 -> f_req_ready_o=1 same cycle; next cycle f_rsp_valid_o=1, f_rsp_instr_o=0x00500093, err=0.
- F and D both valid continuously, MAX_WAIT=4, responses always ready -> F granted 4 cycles, D granted 5th cycle, then F resumes; pattern repeats.
- F request at addr 0x02, then at 0xFE -> both responses err=1, instr=0x00000013, and mem data is ignored.
- F response held with f_rsp_ready_i=0 for 3 cycles, F still valid -> f_req_ready_o=0 and instr stable. Ready=1 with F valid -> drain and reload on the same edge, rsp_valid stays 1.
- F slot valid, f_flush_i=1 with F and D valid -> D granted, F slot cleared next edge, d_rsp_valid_o=1 next edge.
- rst_n_i asserted low while both slots valid -> all rsp_valid drop immediately (asynchronous), counter=0, state ARB_NORMAL.
